// File: rtl/data_buffer_if.sv
// Byte FIFO bus between the register block / packet engines and data_buffer.
//  slave  : the buffer side (takes strobes and push bytes, drives head/occupancy/pulses)
//  master : the user side (register block plus USB RX/TX engines)
//  clear                 sync flush request
//  store_tx_data/tx_data AHB-side push strobe and byte
//  get_rx_data/rx_data   AHB-side pop strobe and head byte
//  store_rx_packet_data/rx_packet_data  USB RX push strobe and byte
//  get_tx_packet_data/tx_packet_data    USB TX pop strobe and head byte
//  buffer_occupancy      registered entry count
//  overrun/underrun      registered 1-cycle error pulses
interface data_buffer_if #(
    parameter int unsigned ADDR_W = 6
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic              clear;
    logic              store_tx_data;
    logic [DATA_W-1:0] tx_data;
    logic              get_rx_data;
    logic [DATA_W-1:0] rx_data;
    logic              store_rx_packet_data;
    logic [DATA_W-1:0] rx_packet_data;
    logic              get_tx_packet_data;
    logic [DATA_W-1:0] tx_packet_data;
    logic [CNT_W-1:0]  buffer_occupancy;
    logic              overrun;
    logic              underrun;

    modport slave (
        input  clear,
        input  store_tx_data,
        input  tx_data,
        input  get_rx_data,
        input  store_rx_packet_data,
        input  rx_packet_data,
        input  get_tx_packet_data,
        output rx_data,
        output tx_packet_data,
        output buffer_occupancy,
        output overrun,
        output underrun
    );

    modport master (
        output clear,
        output store_tx_data,
        output tx_data,
        output get_rx_data,
        output store_rx_packet_data,
        output rx_packet_data,
        output get_tx_packet_data,
        input  rx_data,
        input  tx_packet_data,
        input  buffer_occupancy,
        input  overrun,
        input  underrun
    );
endinterface

// File: rtl/data_buffer.sv
// Shared 64-byte FIFO between the AHB register block and the USB packet engines.
// Ports:
//  clk    rising-edge system clock
//  n_rst  asynchronous active-low reset
//  bus    data_buffer_if.slave: push/pop strobes, push bytes, show-ahead head byte,
//         registered occupancy and registered overrun/underrun pulses
module data_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic         clk,
    input  logic         n_rst,
    data_buffer_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overrun;
    logic              r_underrun;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_overrun_nxt;
    logic              w_underrun_nxt;
    logic [DATA_W-1:0] w_push_data;
    logic [CNT_W-1:0]  w_count_nxt;

    // Push/pop decode; clear masks every strobe and pulse in its cycle
    always_comb begin
        w_push         = bus.store_tx_data | bus.store_rx_packet_data;
        w_pop          = bus.get_rx_data | bus.get_tx_packet_data;
        // AHB byte wins when both sides push together
        w_push_data    = bus.store_tx_data ? bus.tx_data : bus.rx_packet_data;
        w_full         = (r_count == CNT_W'(DEPTH));
        w_empty        = (r_count == '0);
        // A pop on a full buffer frees the slot the push needs
        w_wr_en        = !bus.clear && w_push && (!w_full || w_pop);
        w_rd_en        = !bus.clear && w_pop && !w_empty;
        w_overrun_nxt  = !bus.clear && w_push &&
                         ((w_full && !w_pop) || (bus.store_tx_data && bus.store_rx_packet_data));
        w_underrun_nxt = !bus.clear && w_pop && w_empty;

        w_count_nxt = r_count;
        if (bus.clear) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointers, count and error pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_overrun  <= w_overrun_nxt;
            r_underrun <= w_underrun_nxt;
            if (bus.clear) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_en) r_wptr <= r_wptr + ADDR_W'(1);
                if (w_rd_en) r_rptr <= r_rptr + ADDR_W'(1);
            end
        end
    end

    // Storage array; clear leaves contents in place
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_W'(i)] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    // Show-ahead head byte, forced to zero while empty
    assign bus.rx_data          = w_empty ? DATA_W'(0) : r_mem[r_rptr];
    assign bus.tx_packet_data   = bus.rx_data;
    assign bus.buffer_occupancy = r_count;
    assign bus.overrun          = r_overrun;
    assign bus.underrun         = r_underrun;
endmodule
